// File: rtl/game_ctrl.sv
// game_ctrl: light-cycle game sequencer. Owns the tile map write/read port, clears the map,
// places both players, resolves each move through a read/check/write pipeline and drives mode.
module game_ctrl #(
  parameter int          MAP_WIDTH  = 64,
  parameter int          MAP_HEIGHT = 48,
  parameter logic [5:0]  P1_X0      = 6'd16,
  parameter logic [5:0]  P2_X0      = 6'd47,
  parameter logic [5:0]  START_Y    = 6'd24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        move_tick,
  input  logic [2:0]  dir1,
  input  logic [2:0]  dir2,
  output logic [11:0] map_addr,
  output logic        map_we,
  output logic [1:0]  map_wdata,
  input  logic [1:0]  map_rdata,
  output logic [1:0]  mode,
  output logic        busy
);

  localparam logic [5:0]  X_MAX    = 6'(MAP_WIDTH - 1);
  localparam logic [5:0]  Y_MAX    = 6'(MAP_HEIGHT - 1);
  localparam logic [11:0] CLR_LAST = {Y_MAX, X_MAX};

  localparam logic [2:0] DIR_WAIT  = 3'd0;
  localparam logic [2:0] DIR_RIGHT = 3'd1;
  localparam logic [2:0] DIR_LEFT  = 3'd2;
  localparam logic [2:0] DIR_UP    = 3'd3;
  localparam logic [2:0] DIR_DOWN  = 3'd4;

  localparam logic [1:0] TILE_EMPTY = 2'd0;
  localparam logic [1:0] TILE_P1    = 2'd1;
  localparam logic [1:0] TILE_P2    = 2'd2;
  localparam logic [1:0] TILE_FRAME = 2'd3;

  localparam logic [1:0] MODE_START = 2'd0;
  localparam logic [1:0] MODE_GAME  = 2'd1;
  localparam logic [1:0] MODE_P1WIN = 2'd2;
  localparam logic [1:0] MODE_P2WIN = 2'd3;

  typedef enum logic [3:0] {
    S_CLEAR, S_PLACE1, S_PLACE2, S_READY, S_WAIT,
    S_RD2, S_CHECK, S_WR1, S_WR2, S_WIN
  } state_t;

  function automatic logic [1:0] f_clear_tile(input logic [11:0] a);
    if (a[5:0] == 6'd0 || a[5:0] == X_MAX || a[11:6] == 6'd0 || a[11:6] == Y_MAX) begin
      return TILE_FRAME;
    end else begin
      return TILE_EMPTY;
    end
  endfunction

  // A request is taken only if it is a real direction and not a U-turn.
  function automatic logic [2:0] f_heading(input logic [2:0] cur, input logic [2:0] req);
    logic rev;
    case (cur)
      DIR_RIGHT: rev = (req == DIR_LEFT);
      DIR_LEFT:  rev = (req == DIR_RIGHT);
      DIR_UP:    rev = (req == DIR_DOWN);
      DIR_DOWN:  rev = (req == DIR_UP);
      default:   rev = 1'b0;
    endcase
    if (req == DIR_WAIT || req > DIR_DOWN || rev) begin
      return cur;
    end else begin
      return req;
    end
  endfunction

  function automatic logic [11:0] f_step(input logic [11:0] pos, input logic [2:0] head);
    logic [5:0] x;
    logic [5:0] y;
    x = pos[5:0];
    y = pos[11:6];
    case (head)
      DIR_RIGHT: x = x + 6'd1;
      DIR_LEFT:  x = x - 6'd1;
      DIR_UP:    y = y - 6'd1;
      DIR_DOWN:  y = y + 6'd1;
      default:   x = pos[5:0];
    endcase
    return {y, x};
  endfunction

  state_t      r_state, w_state_nxt;
  logic [11:0] r_map_addr, w_addr_nxt;
  logic        r_map_we, w_we_nxt;
  logic [1:0]  r_map_wdata, w_wdata_nxt;
  logic [1:0]  r_mode, w_mode_nxt;
  logic        r_busy, w_busy_nxt;
  logic [11:0] r_clr, w_clr_nxt;
  logic [11:0] r_pos1, w_pos1_nxt, r_pos2, w_pos2_nxt;
  logic [2:0]  r_head1, w_head1_nxt, r_head2, w_head2_nxt;
  logic [11:0] r_next1, w_next1_nxt, r_next2, w_next2_nxt;
  logic [1:0]  r_rd1, w_rd1_nxt;

  logic [2:0]  w_h1, w_h2;
  logic [11:0] w_next1, w_next2;
  logic        w_same, w_hit1, w_hit2;

  assign w_h1    = f_heading(r_head1, dir1);
  assign w_h2    = f_heading(r_head2, dir2);
  assign w_next1 = f_step(r_pos1, w_h1);
  assign w_next2 = f_step(r_pos2, w_h2);
  assign w_same  = (r_next1 == r_next2);
  assign w_hit1  = (r_rd1 != TILE_EMPTY) || w_same;
  assign w_hit2  = (map_rdata != TILE_EMPTY) || w_same;

  // The player-1 read must be on the bus in the tick cycle itself, so it bypasses the register.
  assign map_addr  = (r_state == S_WAIT) ? w_next1 : r_map_addr;
  assign map_we    = r_map_we;
  assign map_wdata = r_map_wdata;
  assign mode      = r_mode;
  assign busy      = r_busy;

  // Next-state and next-register values for the sequencer.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_map_addr;
    w_we_nxt    = 1'b0;
    w_wdata_nxt = TILE_EMPTY;
    w_mode_nxt  = r_mode;
    w_busy_nxt  = 1'b0;
    w_clr_nxt   = r_clr;
    w_pos1_nxt  = r_pos1;
    w_pos2_nxt  = r_pos2;
    w_head1_nxt = r_head1;
    w_head2_nxt = r_head2;
    w_next1_nxt = r_next1;
    w_next2_nxt = r_next2;
    w_rd1_nxt   = r_rd1;
    case (r_state)
      S_CLEAR: begin
        w_we_nxt    = 1'b1;
        w_addr_nxt  = r_clr;
        w_wdata_nxt = f_clear_tile(r_clr);
        if (r_clr == CLR_LAST) begin
          w_clr_nxt   = 12'd0;
          w_state_nxt = S_PLACE1;
        end else if (r_clr[5:0] == X_MAX) begin
          w_clr_nxt = {r_clr[11:6] + 6'd1, 6'd0};
        end else begin
          w_clr_nxt = r_clr + 12'd1;
        end
      end
      S_PLACE1: begin
        w_we_nxt    = 1'b1;
        w_addr_nxt  = {START_Y, P1_X0};
        w_wdata_nxt = TILE_P1;
        w_pos1_nxt  = {START_Y, P1_X0};
        w_pos2_nxt  = {START_Y, P2_X0};
        w_head1_nxt = DIR_RIGHT;
        w_head2_nxt = DIR_LEFT;
        w_state_nxt = S_PLACE2;
      end
      S_PLACE2: begin
        w_we_nxt    = 1'b1;
        w_addr_nxt  = {START_Y, P2_X0};
        w_wdata_nxt = TILE_P2;
        w_state_nxt = S_READY;
      end
      S_READY: begin
        if (start) begin
          w_mode_nxt  = MODE_GAME;
          w_state_nxt = S_WAIT;
        end else begin
          w_mode_nxt  = MODE_START;
        end
      end
      S_WAIT: begin
        if (move_tick) begin
          w_head1_nxt = w_h1;
          w_head2_nxt = w_h2;
          w_next1_nxt = w_next1;
          w_next2_nxt = w_next2;
          w_addr_nxt  = w_next2;
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_RD2;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_RD2: begin
        w_rd1_nxt   = map_rdata;
        w_busy_nxt  = 1'b1;
        w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (w_hit1 && w_hit2) begin
          w_mode_nxt  = MODE_START;
          w_clr_nxt   = 12'd0;
          w_state_nxt = S_CLEAR;
        end else if (w_hit1) begin
          w_mode_nxt  = MODE_P2WIN;
          w_state_nxt = S_WIN;
        end else if (w_hit2) begin
          w_mode_nxt  = MODE_P1WIN;
          w_state_nxt = S_WIN;
        end else begin
          w_we_nxt    = 1'b1;
          w_addr_nxt  = r_next1;
          w_wdata_nxt = TILE_P1;
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_WR1;
        end
      end
      S_WR1: begin
        w_we_nxt    = 1'b1;
        w_addr_nxt  = r_next2;
        w_wdata_nxt = TILE_P2;
        w_busy_nxt  = 1'b1;
        w_state_nxt = S_WR2;
      end
      S_WR2: begin
        w_pos1_nxt  = r_next1;
        w_pos2_nxt  = r_next2;
        w_state_nxt = S_WAIT;
      end
      S_WIN: begin
        if (start) begin
          w_mode_nxt  = MODE_START;
          w_clr_nxt   = 12'd0;
          w_state_nxt = S_CLEAR;
        end else begin
          w_state_nxt = S_WIN;
        end
      end
      default: begin
        w_clr_nxt   = 12'd0;
        w_state_nxt = S_CLEAR;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered outputs and game datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_map_addr  <= 12'd0;
      r_map_we    <= 1'b0;
      r_map_wdata <= TILE_EMPTY;
      r_mode      <= MODE_START;
      r_busy      <= 1'b0;
      r_clr       <= 12'd0;
      r_pos1      <= {START_Y, P1_X0};
      r_pos2      <= {START_Y, P2_X0};
      r_head1     <= DIR_RIGHT;
      r_head2     <= DIR_LEFT;
      r_next1     <= 12'd0;
      r_next2     <= 12'd0;
      r_rd1       <= TILE_EMPTY;
    end else begin
      r_map_addr  <= w_addr_nxt;
      r_map_we    <= w_we_nxt;
      r_map_wdata <= w_wdata_nxt;
      r_mode      <= w_mode_nxt;
      r_busy      <= w_busy_nxt;
      r_clr       <= w_clr_nxt;
      r_pos1      <= w_pos1_nxt;
      r_pos2      <= w_pos2_nxt;
      r_head1     <= w_head1_nxt;
      r_head2     <= w_head2_nxt;
      r_next1     <= w_next1_nxt;
      r_next2     <= w_next2_nxt;
      r_rd1       <= w_rd1_nxt;
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: tile RAM model plus a grid-level reference game model,
// directed scenarios followed by randomized move rounds.
module tb_game_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        move_tick = 1'b0;
  logic [2:0]  dir1 = 3'd0;
  logic [2:0]  dir2 = 3'd0;
  logic [11:0] map_addr;
  logic        map_we;
  logic [1:0]  map_wdata;
  logic [1:0]  map_rdata;
  logic [1:0]  mode;
  logic        busy;

  game_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .move_tick(move_tick),
    .dir1(dir1), .dir2(dir2), .map_addr(map_addr), .map_we(map_we),
    .map_wdata(map_wdata), .map_rdata(map_rdata), .mode(mode), .busy(busy)
  );

  always #5 clk = ~clk;

  // External tile RAM: synchronous write, one-cycle read latency.
  logic [1:0] ram [0:4095];
  always @(posedge clk) begin
    if (map_we) ram[map_addr] <= map_wdata;
    map_rdata <= ram[map_addr];
  end

  logic [13:0] wr_q[$];
  always @(negedge clk) begin
    if (map_we) wr_q.push_back({map_addr, map_wdata});
  end

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: tile grid, positions, headings and mode.
  int mg [0:4095];
  int m_p1x, m_p1y, m_p2x, m_p2y, m_h1, m_h2, m_mode;
  int dx [0:4] = '{0, 1, -1, 0, 0};
  int dy [0:4] = '{0, 0, 0, -1, 1};
  int opp [0:4] = '{0, 2, 1, 4, 3};

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  function automatic int new_head(input int cur, input int req);
    if (req >= 1 && req <= 4 && req != opp[cur]) return req;
    return cur;
  endfunction

  task automatic model_new_round();
    for (int y = 0; y < 48; y++)
      for (int x = 0; x < 64; x++)
        mg[y*64+x] = (x == 0 || x == 63 || y == 0 || y == 47) ? 3 : 0;
    m_p1x = 16; m_p1y = 24; m_h1 = 1;
    m_p2x = 47; m_p2y = 24; m_h2 = 2;
    mg[24*64+16] = 1;
    mg[24*64+47] = 2;
  endtask

  task automatic wait_clear();
    int n, bad, guard, mism;
    guard = 0;
    while (!map_we && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("clear_begin", int'(map_we), 1);
    n = 0; bad = 0;
    while (map_we && n < 3200) begin
      if (n < 3072 && map_addr != n[11:0]) bad++;
      n++;
      @(negedge clk);
    end
    chk("clear_write_count", n, 3074);
    chk("clear_addr_order", bad, 0);
    model_new_round();
    mism = 0;
    for (int a = 0; a < 3072; a++)
      if (int'(ram[a]) != mg[a]) mism++;
    chk("map_content", mism, 0);
    chk("tile_0_0", int'(ram[0]), 3);
    chk("tile_47_63", int'(ram[3071]), 3);
    chk("tile_1_1", int'(ram[65]), 0);
    chk("tile_p1_start", int'(ram[1552]), 1);
    chk("tile_p2_start", int'(ram[1583]), 2);
    chk("ready_mode", int'(mode), 0);
    chk("ready_we", int'(map_we), 0);
    chk("ready_busy", int'(busy), 0);
    m_mode = 0;
  endtask

  task automatic start_game();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    if (m_mode == 0) m_mode = 1;
    chk("start_mode", int'(mode), m_mode);
  endtask

  task automatic restart_from_win();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("win_restart_mode", int'(mode), 0);
    wait_clear();
  endtask

  task automatic do_tick(input int d1, input int d2, input int len, input bit st);
    int h1, h2, n1x, n1y, n2x, n2y, exp_mode, exp_busy, exp_wr, nloop, busy_cnt;
    bit hit1, hit2, draw;
    logic [13:0] e1, e2;
    wr_q.delete();
    draw = 1'b0;
    h1 = m_h1; h2 = m_h2;
    n1x = 0; n1y = 0; n2x = 0; n2y = 0;
    if (m_mode == 1) begin
      h1 = new_head(m_h1, d1);
      h2 = new_head(m_h2, d2);
      n1x = m_p1x + dx[h1]; n1y = m_p1y + dy[h1];
      n2x = m_p2x + dx[h2]; n2y = m_p2y + dy[h2];
      hit1 = (mg[n1y*64+n1x] != 0) || (n1x == n2x && n1y == n2y);
      hit2 = (mg[n2y*64+n2x] != 0) || (n1x == n2x && n1y == n2y);
      if (hit1 && hit2) begin exp_mode = 0; exp_busy = 2; exp_wr = 0; draw = 1'b1; end
      else if (hit1)    begin exp_mode = 3; exp_busy = 2; exp_wr = 0; end
      else if (hit2)    begin exp_mode = 2; exp_busy = 2; exp_wr = 0; end
      else              begin exp_mode = 1; exp_busy = 4; exp_wr = 2; end
    end else begin
      exp_mode = m_mode; exp_busy = 0; exp_wr = 0;
    end
    nloop = draw ? 2 : 8;
    @(negedge clk);
    dir1 = d1[2:0]; dir2 = d2[2:0]; move_tick = 1'b1; start = st;
    busy_cnt = 0;
    for (int k = 0; k < nloop; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == len - 1) move_tick = 1'b0;
      busy_cnt += int'(busy);
    end
    move_tick = 1'b0;
    chk("busy_cycles", busy_cnt, exp_busy);
    if (draw) begin
      m_mode = 0;
      wait_clear();
      chk("draw_mode", int'(mode), 0);
    end else begin
      chk("move_mode", int'(mode), exp_mode);
      chk("move_writes", wr_q.size(), exp_wr);
      if (exp_wr == 2 && wr_q.size() == 2) begin
        e1 = {6'(n1y), 6'(n1x), 2'd1};
        e2 = {6'(n2y), 6'(n2x), 2'd2};
        chk("p1_write", int'(wr_q[0]), int'(e1));
        chk("p2_write", int'(wr_q[1]), int'(e2));
      end
      if (m_mode == 1 && exp_wr == 2) begin
        mg[n1y*64+n1x] = 1; mg[n2y*64+n2x] = 2;
        m_p1x = n1x; m_p1y = n1y; m_p2x = n2x; m_p2y = n2y;
        m_h1 = h1; m_h2 = h2;
      end
      m_mode = exp_mode;
    end
  endtask

  initial begin
    int guard;
    m_mode = 0;
    repeat (3) @(negedge clk);
    chk("rst_mode", int'(mode), 0);
    chk("rst_we", int'(map_we), 0);
    chk("rst_addr", int'(map_addr), 0);
    chk("rst_wdata", int'(map_wdata), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    wait_clear();

    // Straight moves, then a U-turn request with move_tick held through busy.
    start_game();
    for (int t = 0; t < 5; t++) do_tick(0, 0, 1, 1'b0);
    do_tick(2, 0, 4, 1'b0);
    chk("p1_x_after_6", m_p1x, 22);

    // Player 1 climbs into the top frame while player 2 wanders safely.
    for (int t = 0; t < 24; t++) do_tick(3, (t < 10) ? 4 : 1, 1, 1'b1);
    chk("p2_wins", int'(mode), 3);
    do_tick(1, 1, 1, 1'b0);
    restart_from_win();

    // Head-on collision after 15 moves restarts the round.
    start_game();
    for (int t = 0; t < 16 && m_mode == 1; t++) do_tick(0, 0, 1, 1'b0);
    chk("draw_back_to_start", int'(mode), 0);

    // Randomized rounds.
    for (int r = 0; r < 3; r++) begin
      if (m_mode == 0) start_game();
      for (int t = 0; t < 60 && m_mode == 1; t++)
        do_tick(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)));
      if (m_mode == 2 || m_mode == 3) restart_from_win();
    end

    // Reset in the middle of CLEAR.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    guard = 0;
    while (!(map_we && map_addr == 12'd1000) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    chk("reached_addr_1000", int'(map_addr), 1000);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midclr_rst_we", int'(map_we), 0);
    chk("midclr_rst_addr", int'(map_addr), 0);
    chk("midclr_rst_mode", int'(mode), 0);
    rst_n = 1'b1;
    m_mode = 0;
    wait_clear();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
